// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcodes, FSM state encoding and flag layout.
// Flags are packed {negative, zero, carry, overflow}.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_MUL = 3'd7
    } op_e;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_BUSY = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic [3:0] make_flags(input logic neg, input logic zero,
                                              input logic carry, input logic ovf);
        logic [3:0] f;
        f         = '0;
        f[FLAG_N] = neg;
        f[FLAG_Z] = zero;
        f[FLAG_C] = carry;
        f[FLAG_V] = ovf;
        return f;
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier, one multiplier bit per cycle.
// Bit 0 is folded into the start cycle so done rises WIDTH-1 cycles after start.
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            run    <= 1'b0;
        end else if (start) begin
            acc    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
            mcand  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
            mplier <= b >> 1;
            cnt    <= CW'(WIDTH - 1);
            run    <= 1'b1;
        end else if (run) begin
            if (cnt != '0) begin
                if (mplier[0]) begin
                    acc <= acc + mcand;
                end
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt - 1'b1;
            end else begin
                run <= 1'b0;
            end
        end
    end

    assign done    = run && (cnt == '0);
    assign product = acc;

endmodule

// File: rtl/alu_pipe.sv
// Single-issue ALU with valid/ready handshake; ops 0-6 complete in one cycle,
// MUL runs on the sequential multiplier for WIDTH cycles.
//
// state   | meaning
// IDLE    | no result pending, ready for a new op
// BUSY    | multiply in progress, not ready
// DONE    | result/flags held until out_ready; can accept the next op in the same cycle
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    localparam int SW = $clog2(WIDTH);

    state_t             state;
    op_e                op_sel;
    logic               accept;
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   mul_lo;
    logic               mul_hi_nz;
    logic [SW-1:0]      sh_amt;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic               alu_v;

    assign op_sel    = op_e'(op);
    assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
    assign out_valid = (state == ST_DONE);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (op_sel == OP_MUL);
    assign sh_amt    = b[SW-1:0];
    assign mul_lo    = product[WIDTH-1:0];
    assign mul_hi_nz = |product[2*WIDTH-1:WIDTH];

    // Extra bit on the shifts catches the last bit shifted out as carry.
    always_comb begin
        logic [WIDTH:0] sum;
        logic [WIDTH:0] diff;
        logic [WIDTH:0] shl_ext;
        logic [WIDTH:0] shr_ext;
        sum     = {1'b0, a} + {1'b0, b};
        diff    = {1'b0, a} - {1'b0, b};
        shl_ext = {1'b0, a} << sh_amt;
        shr_ext = {a, 1'b0} >> sh_amt;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_sel)
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = diff[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_SHL: begin
                alu_res = shl_ext[WIDTH-1:0];
                alu_c   = shl_ext[WIDTH];
            end
            OP_SHR: begin
                alu_res = shr_ext[WIDTH:1];
                alu_c   = shr_ext[0];
            end
            default: ;
        endcase
    end

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (product)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            result <= '0;
            flags  <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        if (op_sel == OP_MUL) begin
                            state <= ST_BUSY;
                        end else begin
                            state  <= ST_DONE;
                            result <= alu_res;
                            flags  <= make_flags(alu_res[WIDTH-1], alu_res == '0, alu_c, alu_v);
                        end
                    end else if ((state == ST_DONE) && out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (mul_done) begin
                        state  <= ST_DONE;
                        result <= mul_lo;
                        flags  <= make_flags(mul_lo[WIDTH-1], mul_lo == '0, mul_hi_nz, 1'b0);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: a WIDTH=4 and a WIDTH=8 instance driven with
// directed vectors; per-instance monitors pop expected results on each handshake.
module tb_alu_pipe;

    logic       clk;
    logic       rst_n4, rst_n8;
    logic       iv4, ir4, ov4, or4;
    logic       iv8, ir8, ov8, or8;
    logic [3:0] a4, b4, res4, flg4;
    logic [7:0] a8, b8, res8;
    logic [3:0] flg8;
    logic [2:0] op4, op8;

    int checks;
    int errors;

    logic [7:0] q_r4[$];
    logic [3:0] q_f4[$];
    logic [7:0] q_r8[$];
    logic [3:0] q_f8[$];
    logic [7:0] er4, er8;
    logic [3:0] ef4, ef8;

    alu_pipe #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n4), .in_valid(iv4), .in_ready(ir4),
        .a(a4), .b(b4), .op(op4), .out_valid(ov4), .out_ready(or4),
        .result(res4), .flags(flg4)
    );

    alu_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n8), .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .op(op8), .out_valid(ov8), .out_ready(or8),
        .result(res8), .flags(flg8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n4 && ov4 && or4) begin
            if (q_r4.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out4: got result %0h with empty scoreboard", res4);
            end else begin
                er4 = q_r4.pop_front();
                ef4 = q_f4.pop_front();
                chk("result4", 32'(res4), 32'(er4));
                chk("flags4", 32'(flg4), 32'(ef4));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n8 && ov8 && or8) begin
            if (q_r8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out8: got result %0h with empty scoreboard", res8);
            end else begin
                er8 = q_r8.pop_front();
                ef8 = q_f8.pop_front();
                chk("result8", 32'(res8), 32'(er8));
                chk("flags8", 32'(flg8), 32'(ef8));
            end
        end
    end

    // Offer one op, scramble operands after accept, and measure cycles until out_valid.
    task automatic issue(input bit w8, input logic [2:0] o, input logic [7:0] x,
                         input logic [7:0] y, input logic [7:0] r, input logic [3:0] f,
                         input int lat);
        int n;
        n = 0;
        while (!(w8 ? ir8 : ir4) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (w8) begin
            iv8 = 1'b1; op8 = o; a8 = x; b8 = y;
            q_r8.push_back(r); q_f8.push_back(f);
        end else begin
            iv4 = 1'b1; op4 = o; a4 = x[3:0]; b4 = y[3:0];
            q_r4.push_back(r); q_f4.push_back(f);
        end
        @(posedge clk); #1;
        if (w8) begin
            iv8 = 1'b0; op8 = ~o; a8 = ~x; b8 = ~y;
        end else begin
            iv4 = 1'b0; op4 = ~o; a4 = ~x[3:0]; b4 = ~y[3:0];
        end
        n = 1;
        while (!(w8 ? ov8 : ov4) && n < 40) begin
            chk("busy_in_ready", 32'(w8 ? ir8 : ir4), 32'd0);
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 32'(n), 32'(lat));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n4 = 1'b0; rst_n8 = 1'b0;
        iv4 = 1'b0; or4 = 1'b1; a4 = '0; b4 = '0; op4 = '0;
        iv8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0; op8 = '0;
        #23;
        rst_n4 = 1'b1; rst_n8 = 1'b1;
        #1;
        chk("rst_in_ready4", 32'(ir4), 32'd1);
        chk("rst_out_valid4", 32'(ov4), 32'd0);
        chk("rst_result4", 32'(res4), 32'd0);
        chk("rst_flags4", 32'(flg4), 32'd0);
        chk("rst_in_ready8", 32'(ir8), 32'd1);
        chk("rst_out_valid8", 32'(ov8), 32'd0);
        chk("rst_result8", 32'(res8), 32'd0);
        chk("rst_flags8", 32'(flg8), 32'd0);
        @(posedge clk); #1;

        // WIDTH=4 vectors: op, a, b, result, {N,Z,C,V}, latency
        issue(1'b0, 3'd0, 8'd5, 8'd3, 8'd8,  4'b1001, 1);
        issue(1'b0, 3'd1, 8'd5, 8'd3, 8'd2,  4'b0000, 1);
        issue(1'b0, 3'd2, 8'd5, 8'd3, 8'd1,  4'b0000, 1);
        issue(1'b0, 3'd3, 8'd5, 8'd3, 8'd7,  4'b0000, 1);
        issue(1'b0, 3'd4, 8'd5, 8'd3, 8'd6,  4'b0000, 1);
        issue(1'b0, 3'd1, 8'd3, 8'd5, 8'd14, 4'b1010, 1);
        issue(1'b0, 3'd0, 8'd8, 8'd8, 8'd0,  4'b0111, 1);
        issue(1'b0, 3'd7, 8'd5, 8'd3, 8'd15, 4'b1000, 5);
        issue(1'b0, 3'd7, 8'd5, 8'd5, 8'd9,  4'b1010, 5);
        @(posedge clk); #1;
        chk("idle_after_consume4", 32'(ov4), 32'd0);

        // WIDTH=8 hold in DONE with a competing offer that must be ignored
        issue(1'b1, 3'd0, 8'h10, 8'h20, 8'h30, 4'b0000, 1);
        iv8 = 1'b1; op8 = 3'd0; a8 = 8'h01; b8 = 8'h01;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(ov8), 32'd1);
            chk("hold_result", 32'(res8), 32'h30);
            chk("hold_flags", 32'(flg8), 32'd0);
            chk("hold_in_ready", 32'(ir8), 32'd0);
        end
        a8 = 8'hFF; b8 = 8'h01; op8 = 3'd0;
        q_r8.push_back(8'h00); q_f8.push_back(4'b0110);
        or8 = 1'b1;
        #1;
        chk("b2b_in_ready", 32'(ir8), 32'd1);
        @(posedge clk); #1;
        chk("b2b_no_bubble", 32'(ov8), 32'd1);
        iv8 = 1'b0;
        @(posedge clk); #1;
        chk("idle_after_consume8", 32'(ov8), 32'd0);

        issue(1'b1, 3'd5, 8'h81, 8'hF9, 8'h02, 4'b0010, 1);
        issue(1'b1, 3'd6, 8'h81, 8'h00, 8'h81, 4'b1000, 1);
        issue(1'b1, 3'd5, 8'h81, 8'h00, 8'h81, 4'b1000, 1);
        issue(1'b1, 3'd6, 8'h81, 8'h01, 8'h40, 4'b0010, 1);
        issue(1'b1, 3'd6, 8'h81, 8'h07, 8'h01, 4'b0000, 1);
        issue(1'b1, 3'd7, 8'hC8, 8'h03, 8'h58, 4'b0010, 9);
        issue(1'b1, 3'd7, 8'h0F, 8'h11, 8'hFF, 4'b1000, 9);
        issue(1'b1, 3'd1, 8'h80, 8'h01, 8'h7F, 4'b0001, 1);

        // Reset in the third BUSY cycle of a multiply
        iv8 = 1'b1; op8 = 3'd7; a8 = 8'hC8; b8 = 8'h03;
        @(posedge clk); #1;
        iv8 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("busy_before_reset", 32'(ir8), 32'd0);
        rst_n8 = 1'b0;
        #2;
        chk("reset_result", 32'(res8), 32'd0);
        chk("reset_flags", 32'(flg8), 32'd0);
        chk("reset_valid", 32'(ov8), 32'd0);
        #1;
        rst_n8 = 1'b1;
        #2;
        chk("ready_after_release", 32'(ir8), 32'd1);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            chk("no_valid_after_reset", 32'(ov8), 32'd0);
        end
        issue(1'b1, 3'd0, 8'h7F, 8'h01, 8'h80, 4'b1001, 1);
        issue(1'b1, 3'd7, 8'h00, 8'h37, 8'h00, 4'b0100, 9);

        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("scoreboard_empty4", 32'(q_r4.size()), 32'd0);
        chk("scoreboard_empty8", 32'(q_r8.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
